// File: rtl/eth_arb_pkg.sv
// rtl/eth_arb_pkg.sv - shared types and defaults for the Ethernet TX arbiter
package eth_arb_pkg;

  localparam int NUM_PORTS_DEF   = 3;
  localparam int DATA_WIDTH_DEF  = 256;
  localparam int EMPTY_WIDTH_DEF = 5;

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  typedef struct packed {
    logic [DATA_WIDTH_DEF-1:0]  data;
    logic                       sop;
    logic                       eop;
    logic [EMPTY_WIDTH_DEF-1:0] empty;
    logic                       error;
  } beat_t;

endpackage

// File: rtl/eth_tx_arbiter_if.sv
// rtl/eth_tx_arbiter_if.sv - per-NIC input streams and the shared MAC TX stream
interface eth_tx_arbiter_if
  import eth_arb_pkg::*;
#(
  parameter int NUM_PORTS   = NUM_PORTS_DEF,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int EMPTY_WIDTH = EMPTY_WIDTH_DEF
);

  logic                   in_valid [NUM_PORTS];
  logic                   in_sop   [NUM_PORTS];
  logic                   in_eop   [NUM_PORTS];
  logic                   in_error [NUM_PORTS];
  logic [DATA_WIDTH-1:0]  in_data  [NUM_PORTS];
  logic [EMPTY_WIDTH-1:0] in_empty [NUM_PORTS];
  logic                   in_ready [NUM_PORTS];

  logic                   out_valid;
  logic                   out_sop;
  logic                   out_eop;
  logic                   out_error;
  logic [DATA_WIDTH-1:0]  out_data;
  logic [EMPTY_WIDTH-1:0] out_empty;
  logic                   out_ready;

  // master: NICs plus MAC (the environment); slave: the arbiter
  modport master (
    output in_valid, in_sop, in_eop, in_error, in_data, in_empty,
    input  in_ready,
    input  out_valid, out_sop, out_eop, out_error, out_data, out_empty,
    output out_ready
  );

  modport slave (
    input  in_valid, in_sop, in_eop, in_error, in_data, in_empty,
    output in_ready,
    output out_valid, out_sop, out_eop, out_error, out_data, out_empty,
    input  out_ready
  );

endinterface

// File: rtl/eth_arb_rr_pick.sv
// rtl/eth_arb_rr_pick.sv - combinational round-robin picker starting at rr_ptr
module eth_arb_rr_pick #(
  parameter  int NUM_PORTS = 3,
  localparam int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     rr_ptr,
  output logic                 found,
  output logic [IDX_W-1:0]     idx
);

  int cand;

  // Scan from the farthest offset down so the nearest requester to rr_ptr wins.
  always_comb begin
    found = 1'b0;
    idx   = rr_ptr;
    cand  = 0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
      if (req[cand]) begin
        found = 1'b1;
        idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/eth_tx_arbiter.sv
// rtl/eth_tx_arbiter.sv - packet-granular round-robin arbiter onto one MAC TX stream
module eth_tx_arbiter
  import eth_arb_pkg::*;
#(
  parameter  int NUM_PORTS   = NUM_PORTS_DEF,
  parameter  int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter  int EMPTY_WIDTH = EMPTY_WIDTH_DEF,
  localparam int IDX_W       = $clog2(NUM_PORTS)
) (
  input  logic             clk,
  input  logic             reset,
  eth_tx_arbiter_if.slave  bus,
  output logic             busy,
  output logic [IDX_W-1:0] grant_idx,
  output logic [15:0]      drop_cnt
);

  state_t                 state;
  logic [IDX_W-1:0]       rr_ptr;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_found;
  logic                   stage_en;
  logic                   accept;
  logic                   last_beat;
  logic [NUM_PORTS-1:0]   req;
  logic [NUM_PORTS-1:0]   flush;
  logic [3:0]             flush_n;
  logic [16:0]            drop_sum;

  logic                   out_valid_q;
  logic                   out_sop_q;
  logic                   out_eop_q;
  logic                   out_error_q;
  logic [DATA_WIDTH-1:0]  out_data_q;
  logic [EMPTY_WIDTH-1:0] out_empty_q;

  always_comb begin
    stage_en = bus.out_ready || !out_valid_q;
    req      = '0;
    flush    = '0;
    flush_n  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      req[i]   = bus.in_valid[i] && bus.in_sop[i];
      // Beats without SOP seen while idle belong to no frame; swallow them.
      flush[i] = (state == S_IDLE) && bus.in_valid[i] && !bus.in_sop[i];
      flush_n  = flush_n + 4'(flush[i]);
    end
    accept    = (state == S_BUSY) && stage_en && bus.in_valid[grant_idx];
    last_beat = accept && bus.in_eop[grant_idx];
    drop_sum  = {1'b0, drop_cnt} + 17'(flush_n);
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_ready
    assign bus.in_ready[g] = flush[g] ||
                             ((state == S_BUSY) && (grant_idx == IDX_W'(g)) && stage_en);
  end

  eth_arb_rr_pick #(.NUM_PORTS(NUM_PORTS)) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .found  (pick_found),
    .idx    (pick_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      grant_idx   <= '0;
      busy        <= 1'b0;
      drop_cnt    <= '0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_error_q <= 1'b0;
      out_data_q  <= '0;
      out_empty_q <= '0;
    end else begin
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

      if (stage_en) begin
        out_valid_q <= accept;
        if (accept) begin
          out_sop_q   <= bus.in_sop[grant_idx];
          out_eop_q   <= bus.in_eop[grant_idx];
          out_error_q <= bus.in_error[grant_idx];
          out_data_q  <= bus.in_data[grant_idx];
          out_empty_q <= bus.in_empty[grant_idx];
        end
      end

      case (state)
        S_IDLE: begin
          if (pick_found) begin
            grant_idx <= pick_idx;
            state     <= S_BUSY;
            busy      <= 1'b1;
          end
        end
        S_BUSY: begin
          if (last_beat) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            rr_ptr <= (grant_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_idx + IDX_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_sop   = out_sop_q;
  assign bus.out_eop   = out_eop_q;
  assign bus.out_error = out_error_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_empty = out_empty_q;

endmodule
